move_collector: RTL and testbench

MOVE_COLLECTOR -- requirements
Module: move_collector

---
 rtl/chess_pkg.sv | 49 ++++
 rtl/move_fifo.sv | 52 +++++
 rtl/move_collector.sv | 155 +++++++++++++++
 tb/tb_move_collector.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// chess_pkg: shared definitions for the move collector.
//   - Move-word field offsets/widths and the reserved-bit mask.
//   - EMPTY_MOVE_OUT: value shown on the move outputs when nothing is queued.
//   - dir_e: 4-bit direction encoding, equal to the snapshot word index.
//   - move_t: one queued move, as carried through the output FIFO.
//   - state_e: collector FSM states.
package chess_pkg;

   localparam int NUM_DIRS = 16;
   localparam int WORD_W   = 32;
   localparam int IDX_W    = 4;

   localparam int CAP_LSB   = 24;
   localparam int CAP_W     = 6;
   localparam int FROM_LSB  = 16;
   localparam int FROM_W    = 6;
   localparam int PIECE_LSB = 9;
   localparam int PIECE_W   = 5;
   localparam int FLAG_BIT  = 8;
   localparam int TO_LSB    = 0;
   localparam int TO_W      = 6;

   // Bits [31:30], [23:22], [15:14], [7:6] carry no field.
   localparam logic [WORD_W-1:0] RSVD_MASK      = 32'hC0C0_C0C0;
   localparam logic [WORD_W-1:0] EMPTY_MOVE_OUT = 32'h0000_0000;

   typedef enum logic [IDX_W-1:0] {
      DIR_U   = 4'd0,  DIR_D   = 4'd1,  DIR_L   = 4'd2,  DIR_R   = 4'd3,
      DIR_UL  = 4'd4,  DIR_UR  = 4'd5,  DIR_DL  = 4'd6,  DIR_DR  = 4'd7,
      DIR_UUL = 4'd8,  DIR_UUR = 4'd9,  DIR_LLU = 4'd10, DIR_RRU = 4'd11,
      DIR_DDL = 4'd12, DIR_DDR = 4'd13, DIR_LLD = 4'd14, DIR_RRD = 4'd15
   } dir_e;

   typedef struct packed {
      logic [CAP_W-1:0]   capture;
      logic [FROM_W-1:0]  from;
      logic [PIECE_W-1:0] piece;
      logic               flag;
      logic [TO_W-1:0]    to;
      dir_e               dir;
   } move_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/move_fifo.sv
// move_fifo: synchronous FIFO, DEPTH entries (power of two) of W bits.
// Ports:
//   clk, clear         clock, synchronous active-high reset (empties FIFO)
//   push, din          write request / data; ignored while full
//   pop, dout          read request / head data; pop ignored while empty
//   full, empty        occupancy flags
module move_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 28
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/move_collector.sv
// move_collector: latches a 16-word move snapshot, scans it one word per
// cycle in index order, and queues every non-empty word as a decoded move
// into an output FIFO drained through a valid/ready handshake.
// Ports:
//   clk, clear              clock, synchronous active-high reset
//   snap_valid, snap_ready  snapshot handshake (ready only in IDLE)
//   moves_in[511:0]         16 packed move words, word i at [32i+31:32i]
//   mv_valid, mv_ready      output handshake; mv_valid = FIFO non-empty
//   mv_capture/from/piece/flag/to/dir   FIFO head fields (zero when empty)
//   scan_done               one-cycle pulse when a scan has fully drained
//   move_count              non-empty words queued from the last snapshot
//   err_count               saturating count of dropped malformed words
// Build option: define MOVE_CHECK_EN to drop words with reserved bits set;
// without it reserved bits are ignored and err_count is tied to 0.
module move_collector
   import chess_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      clear,
   input  logic                      snap_valid,
   output logic                      snap_ready,
   input  logic [NUM_DIRS*WORD_W-1:0] moves_in,
   output logic                      mv_valid,
   input  logic                      mv_ready,
   output logic [CAP_W-1:0]          mv_capture,
   output logic [FROM_W-1:0]         mv_from,
   output logic [PIECE_W-1:0]        mv_piece,
   output logic                      mv_flag,
   output logic [TO_W-1:0]           mv_to,
   output logic [IDX_W-1:0]          mv_dir,
   output logic                      scan_done,
   output logic [4:0]                move_count,
   output logic [7:0]                err_count
);

   localparam int MW = $bits(move_t);

   state_e                            state_q, state_d;
   logic [NUM_DIRS-1:0][WORD_W-1:0]   snap_q;
   logic [IDX_W-1:0]                  idx_q;
   logic [4:0]                        cnt_q;
   logic [WORD_W-1:0]                 cur_word;
   move_t                             cur_move, head;
   logic [MW-1:0]                     fifo_dout;
   logic                              fifo_full, fifo_empty;
   logic                              push, pop, consume, bad_word, accept;

   assign cur_word = snap_q[idx_q];
   assign accept   = (state_q == ST_IDLE) & snap_valid;

`ifdef MOVE_CHECK_EN
   assign bad_word = |(cur_word & RSVD_MASK);
`else
   assign bad_word = 1'b0;
`endif

   always_comb begin
      cur_move         = '0;
      cur_move.capture = cur_word[CAP_LSB +: CAP_W];
      cur_move.from    = cur_word[FROM_LSB +: FROM_W];
      cur_move.piece   = cur_word[PIECE_LSB +: PIECE_W];
      cur_move.flag    = cur_word[FLAG_BIT];
      cur_move.to      = cur_word[TO_LSB +: TO_W];
      cur_move.dir     = dir_e'(idx_q);
   end

   // Next state / scan control. A word is consumed when skipped, dropped or
   // pushed; a valid word meeting a full FIFO stalls even if a pop happens
   // this cycle, since the push decision looks only at the registered flag.
   always_comb begin
      state_d    = state_q;
      push       = 1'b0;
      consume    = 1'b0;
      scan_done  = 1'b0;
      snap_ready = (state_q == ST_IDLE);
      case (state_q)
         ST_IDLE:  if (snap_valid) state_d = ST_SCAN;
         ST_SCAN: begin
            if (cur_word == '0 || bad_word) begin
               consume = 1'b1;
            end else if (!fifo_full) begin
               push    = 1'b1;
               consume = 1'b1;
            end
            if (consume && idx_q == IDX_W'(NUM_DIRS-1)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               scan_done = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= ST_IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            snap_q <= moves_in;
            idx_q  <= '0;
            cnt_q  <= '0;
         end
         // Index parks at 15 at the end of a scan instead of wrapping.
         if (consume && idx_q != IDX_W'(NUM_DIRS-1)) idx_q <= idx_q + 1'b1;
         if (push) cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef MOVE_CHECK_EN
   logic [7:0] err_q;
   logic       drop;
   assign drop = (state_q == ST_SCAN) & (cur_word != '0) & bad_word;

   always_ff @(posedge clk) begin
      if (clear)                     err_q <= '0;
      else if (drop && err_q != '1)  err_q <= err_q + 1'b1;
   end
   assign err_count = err_q;
`else
   assign err_count = '0;
`endif

   move_fifo #(.DEPTH(FIFO_DEPTH), .W(MW)) u_fifo (
      .clk   (clk),
      .clear (clear),
      .push  (push),
      .din   (cur_move),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign mv_valid = ~fifo_empty;
   assign pop      = mv_valid & mv_ready;
   assign head     = fifo_empty ? move_t'(EMPTY_MOVE_OUT[MW-1:0]) : move_t'(fifo_dout);

   assign mv_capture = head.capture;
   assign mv_from    = head.from;
   assign mv_piece   = head.piece;
   assign mv_flag    = head.flag;
   assign mv_to      = head.to;
   assign mv_dir     = head.dir;
   assign move_count = cnt_q;

endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: table-driven single-word snapshots plus hand-written
// sequences for back-pressure stall, all-zero scan, ignored snap_valid
// during a scan, and clear in the middle of a scan.
module tb_move_collector;

   logic         clk = 1'b0;
   logic         clear, snap_valid, snap_ready, mv_valid, mv_ready;
   logic [511:0] moves_in;
   logic [5:0]   mv_capture, mv_from, mv_to;
   logic [4:0]   mv_piece, move_count;
   logic         mv_flag, scan_done;
   logic [3:0]   mv_dir;
   logic [7:0]   err_count;

   move_collector #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .clear(clear), .snap_valid(snap_valid), .snap_ready(snap_ready),
      .moves_in(moves_in), .mv_valid(mv_valid), .mv_ready(mv_ready),
      .mv_capture(mv_capture), .mv_from(mv_from), .mv_piece(mv_piece),
      .mv_flag(mv_flag), .mv_to(mv_to), .mv_dir(mv_dir),
      .scan_done(scan_done), .move_count(move_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] cap;
      logic [5:0] from;
      logic [4:0] piece;
      logic       flag;
      logic [5:0] to;
      logic [3:0] dir;
   } obs_t;

   typedef struct {
      int          dir;
      logic [31:0] word;
      int          n;
      int          first;
      int          done;
      int          drop;
      obs_t        exp;
   } vec_t;

   vec_t tbl [6];
   obs_t got [$];
   int   errors = 0, checks = 0;
   int   cyc, first_v, done_at, exp_err;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic obs_t mk_obs(input int c, input int f, input int p, input int fl,
                                   input int t, input int d);
      obs_t o;
      o.cap = 6'(c); o.from = 6'(f); o.piece = 5'(p); o.flag = 1'(fl);
      o.to = 6'(t); o.dir = 4'(d);
      return o;
   endfunction

   // Bench-side encoder for the stall/clear sequences: word i carries
   // capture=i, from=i+1, piece=i, flag=i[0], to=i+2.
   function automatic logic [31:0] mk_word(input int i);
      logic [31:0] w;
      w = '0;
      w[29:24] = 6'(i);
      w[21:16] = 6'(i + 1);
      w[13:9]  = 5'(i);
      w[8]     = 1'(i % 2);
      w[5:0]   = 6'(i + 2);
      return w;
   endfunction

   function automatic obs_t head_now();
      return {mv_capture, mv_from, mv_piece, mv_flag, mv_to, mv_dir};
   endfunction

   // Presents a snapshot for one edge; returns in cycle N+1 with cyc=1.
   task automatic start_snap(input logic [511:0] m);
      int k;
      got.delete();
      for (k = 0; k < 50 && !snap_ready; k++) begin
         @(posedge clk); #1;
      end
      if (!snap_ready) chk("snap_ready_wait", 0, 1);
      snap_valid = 1'b1;
      moves_in   = m;
      @(posedge clk); #1;
      snap_valid = 1'b0;
      cyc        = 1;
   endtask

   // Runs until scan_done (bounded), recording accepted moves, then steps
   // one edge so the collector is back in IDLE.
   task automatic collect(input logic rdy);
      mv_ready = rdy;
      first_v  = -1;
      done_at  = -1;
      for (int k = 0; k < 300; k++) begin
         if (mv_valid && first_v < 0) first_v = cyc;
         if (mv_valid && mv_ready) got.push_back(head_now());
         if (scan_done) begin
            done_at = cyc;
            break;
         end
         @(posedge clk); #1;
         cyc++;
         snap_valid = 1'b0;
      end
      if (done_at < 0) chk("scan_done_timeout", done_at, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [511:0] m;
      obs_t h0;
      int   unstable, seen;

      clear = 1'b1; snap_valid = 1'b0; mv_ready = 1'b0; moves_in = '0;
      exp_err = 0;

      tbl[0] = '{dir:0,  word:32'h0512_2C1C, n:1, first:2,  done:17, drop:0, exp:mk_obs(5,18,22,0,28,0)};
      tbl[1] = '{dir:15, word:32'h3F3F_3F3F, n:1, first:17, done:18, drop:0, exp:mk_obs(63,63,31,1,63,15)};
      tbl[2] = '{dir:7,  word:32'h0000_0100, n:1, first:9,  done:17, drop:0, exp:mk_obs(0,0,0,1,0,7)};
      tbl[3] = '{dir:9,  word:32'h0000_0200, n:1, first:11, done:17, drop:0, exp:mk_obs(0,0,1,0,0,9)};
`ifdef MOVE_CHECK_EN
      tbl[4] = '{dir:3,  word:32'h4000_0001, n:0, first:-1, done:17, drop:1, exp:mk_obs(0,0,0,0,0,0)};
`else
      tbl[4] = '{dir:3,  word:32'h4000_0001, n:1, first:5,  done:17, drop:0, exp:mk_obs(0,0,0,0,1,3)};
`endif
      tbl[5] = '{dir:12, word:32'h0100_0000, n:1, first:14, done:17, drop:0, exp:mk_obs(1,0,0,0,0,12)};

      // Reset state
      repeat (3) @(posedge clk);
      #1 clear = 1'b0;
      chk("rst_snap_ready", snap_ready, 1);
      chk("rst_mv_valid",   mv_valid, 0);
      chk("rst_fields",     int'(head_now()), 0);
      chk("rst_scan_done",  scan_done, 0);
      chk("rst_move_count", move_count, 0);
      chk("rst_err_count",  err_count, 0);

      // Single-word snapshots
      foreach (tbl[i]) begin
         m = '0;
         m[tbl[i].dir*32 +: 32] = tbl[i].word;
         start_snap(m);
         collect(1'b1);
         exp_err += tbl[i].drop;
         chk($sformatf("v%0d_nmoves", i), got.size(), tbl[i].n);
         chk($sformatf("v%0d_first_valid", i), first_v, tbl[i].first);
         if (tbl[i].n > 0)
            chk($sformatf("v%0d_fields", i), (got.size() > 0) ? int'(got[0]) : -1, int'(tbl[i].exp));
         chk($sformatf("v%0d_done_at", i), done_at, tbl[i].done);
         chk($sformatf("v%0d_move_count", i), move_count, tbl[i].n);
         chk($sformatf("v%0d_err_count", i), err_count, exp_err);
      end

      // All-zero snapshot
      start_snap('0);
      collect(1'b1);
      chk("zero_nmoves", got.size(), 0);
      chk("zero_no_valid", first_v, -1);
      chk("zero_done_at", done_at, 17);
      chk("zero_move_count", move_count, 0);

      // Back-pressure: FIFO fills with words 0..3, scan stalls at index 4.
      m = '0;
      for (int i = 0; i < 16; i++) m[i*32 +: 32] = mk_word(i);
      mv_ready = 1'b0;
      start_snap(m);
      unstable = 0; seen = 0; h0 = '0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (scan_done) seen++;
         if (mv_valid) begin
            if (h0 == '0) h0 = head_now();
            else if (head_now() != h0) unstable++;
         end
      end
      chk("stall_mv_valid", mv_valid, 1);
      chk("stall_head", int'(head_now()), int'(mk_obs(0,1,0,0,2,0)));
      chk("stall_head_stable", unstable, 0);
      chk("stall_move_count", move_count, 4);
      chk("stall_no_done", seen, 0);
      collect(1'b1);
      chk("stall_nmoves", got.size(), 16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("stall_move%0d", i), (i < got.size()) ? int'(got[i]) : -1,
             int'(mk_obs(i, i+1, i, i%2, i+2, i)));
      // Ready rises at cycle 21 with a full FIFO: that pop cannot make room
      // for a push, so index 15 lands at cycle 33 and the last pop at 36.
      chk("stall_done_at", done_at, 37);
      chk("stall_move_count_end", move_count, 16);

      // snap_valid during SCAN with different data must be ignored.
      m = '0;
      m[0*32 +: 32] = 32'h0512_2C1C;
      m[5*32 +: 32] = 32'h3F3F_3F3F;
      start_snap(m);
      snap_valid = 1'b1;
      moves_in   = '0;
      moves_in[0*32 +: 32] = 32'h0100_0000;
      moves_in[1*32 +: 32] = 32'h0000_0100;
      collect(1'b1);
      chk("ign_nmoves", got.size(), 2);
      chk("ign_move0", (got.size() > 0) ? int'(got[0]) : -1, int'(mk_obs(5,18,22,0,28,0)));
      chk("ign_move1", (got.size() > 1) ? int'(got[1]) : -1, int'(mk_obs(63,63,31,1,63,5)));
      chk("ign_done_at", done_at, 17);
      chk("ign_move_count", move_count, 2);

      // clear with three moves queued mid-SCAN
      m = '0;
      for (int i = 0; i < 16; i++) m[i*32 +: 32] = mk_word(i);
      mv_ready = 1'b0;
      start_snap(m);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("clr_pre_count", move_count, 3);
      chk("clr_pre_valid", mv_valid, 1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clr_mv_valid", mv_valid, 0);
      chk("clr_snap_ready", snap_ready, 1);
      chk("clr_scan_done", scan_done, 0);
      chk("clr_move_count", move_count, 0);
      chk("clr_err_count", err_count, 0);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (scan_done || mv_valid) seen++;
         @(posedge clk); #1;
      end
      chk("clr_quiet", seen, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
